// File: rtl/bat_serial_loader.sv
// bat_serial_loader: receives a framed program image over UART (8N1, LSB
// first), writes each 16-bit word into CPU RAM through the external RAM port
// while holding the CPU in HALT, then releases HALT and issues a timed CPU
// reset pulse once the frame checksum matches.
// Frame: A5, [BASE_HI, BASE_LO], LEN_HI, LEN_LO, 2*LEN data bytes, CHK.
// Optional feature macro: BAT_LOADER_BASEADDR_EN adds the BASE_HI/BASE_LO
// bytes; without it every frame loads from address 0x0000.
module bat_serial_loader #(
  parameter int CLKS_PER_BIT = 16,
  parameter int RST_CYCLES   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        RX,
  output logic        HALT,
  output logic [15:0] ADDRESS,
  output logic [15:0] DATA,
  output logic        EXT_RAM_EN,
  output logic        EXT_RAM_RW,
  output logic        CPU_RST_N,
  output logic        BUSY,
  output logic        ERR,
  output logic        DONE
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int RC_W = $clog2(RST_CYCLES) + 1;
  localparam logic [RC_W-1:0] RC_ZERO = RC_W'(0);
  localparam logic [RC_W-1:0] RC_ONE  = RC_W'(1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [3:0] {
    P_WAIT_SYNC, P_BASE_HI, P_BASE_LO, P_LEN_HI, P_LEN_LO, P_DATA_HI,
    P_DATA_LO, P_WRITE, P_CHECK, P_BOOT, P_RUN
  } p_state_e;

`ifdef BAT_LOADER_BASEADDR_EN
  localparam p_state_e FIRST_HDR = P_BASE_HI;
`else
  localparam p_state_e FIRST_HDR = P_LEN_HI;
`endif

  // UART receiver state
  logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d, byte_q, byte_d;
  logic             byte_stb_q, byte_stb_d, frm_err_q, frm_err_d;

  // Parser state
  p_state_e         p_state_q, p_state_d;
  logic [7:0]       len_hi_q, len_hi_d, chk_q, chk_d;
  logic [15:0]      base_q, base_d, cnt_q, cnt_d, addr_q, addr_d, data_q, data_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic             halt_q, halt_d, cpu_rst_n_q, cpu_rst_n_d;
  logic             ext_en_q, ext_en_d, ext_rw_q, ext_rw_d;
  logic             busy_q, busy_d, err_q, err_d, done_q, done_d;
  logic [15:0]      base_s;

`ifdef BAT_LOADER_BASEADDR_EN
  assign base_s = base_q;
`else
  assign base_s = 16'h0000;
`endif

  // UART next state: synchronize RX, detect start edge, sample bits mid-bit
  always_comb begin
    rx_meta_d  = RX;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_state_d = rx_state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    byte_stb_d = 1'b0;
    frm_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        bit_cnt_d = CNT_ZERO;
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (bit_cnt_q == HALF_LAST) begin
          bit_cnt_d = CNT_ZERO;
          bit_idx_d = 3'd0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = CNT_ZERO;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d  = CNT_ZERO;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_stb_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frm_err_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Parser next state: frame decoding, RAM write strobes and boot sequencing
  always_comb begin
    p_state_d   = p_state_q;
    len_hi_d    = len_hi_q;
    chk_d       = chk_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rst_cnt_d   = rst_cnt_q;
    halt_d      = halt_q;
    cpu_rst_n_d = cpu_rst_n_q;
    ext_en_d    = 1'b0;
    ext_rw_d    = 1'b1;
    busy_d      = busy_q;
    err_d       = err_q;
    done_d      = done_q;
    case (p_state_q)
      P_WAIT_SYNC, P_RUN: begin
        if (byte_stb_q && (byte_q == SYNC_BYTE)) begin
          busy_d    = 1'b1;
          err_d     = 1'b0;
          done_d    = 1'b0;
          halt_d    = 1'b1;
          chk_d     = 8'h00;
          p_state_d = FIRST_HDR;
        end else if (frm_err_q) begin
          err_d = 1'b1;
        end else begin
          p_state_d = p_state_q;
        end
      end
      P_WRITE: begin
        // Strobe was asserted for this one cycle; advance to the next word.
        addr_d = addr_q + 16'h0001;
        cnt_d  = cnt_q - 16'h0001;
        if (cnt_q == 16'h0001) begin
          p_state_d = P_CHECK;
        end else begin
          p_state_d = P_DATA_HI;
        end
      end
      P_BOOT: begin
        // HALT is already low; hold the CPU in reset for RST_CYCLES cycles.
        if (rst_cnt_q == RC_LAST) begin
          cpu_rst_n_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = 1'b1;
          p_state_d   = P_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RC_ONE;
        end
      end
      default: begin
        if (frm_err_q) begin
          err_d     = 1'b1;
          busy_d    = 1'b0;
          p_state_d = P_WAIT_SYNC;
        end else if (byte_stb_q) begin
          chk_d = chk_q ^ byte_q;
          case (p_state_q)
            P_BASE_HI: begin base_d[15:8] = byte_q; p_state_d = P_BASE_LO; end
            P_BASE_LO: begin base_d[7:0]  = byte_q; p_state_d = P_LEN_HI;  end
            P_LEN_HI:  begin len_hi_d     = byte_q; p_state_d = P_LEN_LO;  end
            P_LEN_LO: begin
              if ({len_hi_q, byte_q} == 16'h0000) begin
                p_state_d = P_CHECK;
              end else begin
                addr_d    = base_s;
                cnt_d     = {len_hi_q, byte_q};
                p_state_d = P_DATA_HI;
              end
            end
            P_DATA_HI: begin data_d[15:8] = byte_q; p_state_d = P_DATA_LO; end
            P_DATA_LO: begin
              data_d[7:0] = byte_q;
              ext_en_d    = 1'b1;
              ext_rw_d    = 1'b0;
              p_state_d   = P_WRITE;
            end
            P_CHECK: begin
              if (byte_q == chk_q) begin
                halt_d      = 1'b0;
                cpu_rst_n_d = 1'b0;
                rst_cnt_d   = RC_ZERO;
                p_state_d   = P_BOOT;
              end else begin
                err_d     = 1'b1;
                busy_d    = 1'b0;
                p_state_d = P_WAIT_SYNC;
              end
            end
            default: p_state_d = P_WAIT_SYNC;
          endcase
        end else begin
          p_state_d = p_state_q;
        end
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      bit_cnt_q   <= CNT_ZERO;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_q      <= 8'h00;
      byte_stb_q  <= 1'b0;
      frm_err_q   <= 1'b0;
      p_state_q   <= P_WAIT_SYNC;
      len_hi_q    <= 8'h00;
      chk_q       <= 8'h00;
      base_q      <= 16'h0000;
      cnt_q       <= 16'h0000;
      addr_q      <= 16'h0000;
      data_q      <= 16'h0000;
      rst_cnt_q   <= RC_ZERO;
      halt_q      <= 1'b1;
      cpu_rst_n_q <= 1'b0;
      ext_en_q    <= 1'b0;
      ext_rw_q    <= 1'b1;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_q      <= byte_d;
      byte_stb_q  <= byte_stb_d;
      frm_err_q   <= frm_err_d;
      p_state_q   <= p_state_d;
      len_hi_q    <= len_hi_d;
      chk_q       <= chk_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rst_cnt_q   <= rst_cnt_d;
      halt_q      <= halt_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      ext_en_q    <= ext_en_d;
      ext_rw_q    <= ext_rw_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      done_q      <= done_d;
    end
  end

  assign HALT       = halt_q;
  assign ADDRESS    = addr_q;
  assign DATA       = data_q;
  assign EXT_RAM_EN = ext_en_q;
  assign EXT_RAM_RW = ext_rw_q;
  assign CPU_RST_N  = cpu_rst_n_q;
  assign BUSY       = busy_q;
  assign ERR        = err_q;
  assign DONE       = done_q;

endmodule

// File: tb/tb_bat_serial_loader.sv
// Scoreboard bench for bat_serial_loader: the frame builder derives the
// expected RAM writes and the frame outcome (boot or error) from the frame
// contents and queues them; a negedge monitor pops one entry per observed
// write strobe, error rise or CPU reset release.
module tb_bat_serial_loader;
  localparam int CPB  = 16;
  localparam int RSTC = 4;
  localparam int K_WR = 0, K_BOOT = 1, K_ERR = 2;
`ifdef BAT_LOADER_BASEADDR_EN
  localparam int HDR = 5;
`else
  localparam int HDR = 3;
`endif

  logic CLK = 1'b0, RST = 1'b0, RX = 1'b1;
  logic HALT, EXT_RAM_EN, EXT_RAM_RW, CPU_RST_N, BUSY, ERR, DONE;
  logic [15:0] ADDRESS, DATA;

  bat_serial_loader #(.CLKS_PER_BIT(CPB), .RST_CYCLES(RSTC)) dut (
    .CLK(CLK), .RST(RST), .RX(RX), .HALT(HALT), .ADDRESS(ADDRESS), .DATA(DATA),
    .EXT_RAM_EN(EXT_RAM_EN), .EXT_RAM_RW(EXT_RAM_RW), .CPU_RST_N(CPU_RST_N),
    .BUSY(BUSY), .ERR(ERR), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  int vec = 0, miscmp = 0;
  int          exp_kind[$];
  logic [15:0] exp_addr[$], exp_data[$];
  logic [15:0] words[$];
  bit mon_en = 1'b0;
  logic prev_en = 1'b0, prev_err = 1'b0, prev_busy = 1'b0, prev_rstn = 1'b0, prev_halt = 1'b1;
  int boot_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [15:0] a, input logic [15:0] d);
    exp_kind.push_back(kind);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  task automatic pop_expect(input string name, input int kind, input logic [15:0] a,
                            input logic [15:0] d);
    int k;
    logic [15:0] ea, ed;
    check({name, "_expected"}, 32'(exp_kind.size() != 0), 32'd1);
    if (exp_kind.size() != 0) begin
      k  = exp_kind.pop_front();
      ea = exp_addr.pop_front();
      ed = exp_data.pop_front();
      check({name, "_kind"}, 32'(k), 32'(kind));
      if (kind == K_WR) begin
        check({name, "_addr"}, 32'(a), 32'(ea));
        check({name, "_data"}, 32'(d), 32'(ed));
      end
    end
  endtask

  // Monitor: observe DUT events away from the active edge and score them
  always @(negedge CLK) begin
    if (mon_en) begin
      if (EXT_RAM_EN) begin
        check("wr_halt", 32'(HALT), 32'd1);
        check("wr_rw", 32'(EXT_RAM_RW), 32'd0);
        check("wr_single_cycle", 32'(prev_en), 32'd0);
        pop_expect("write", K_WR, ADDRESS, DATA);
      end
      if (ERR && !prev_err) begin
        check("err_halt", 32'(HALT), 32'd1);
        check("err_busy", 32'(BUSY), 32'd0);
        check("err_done", 32'(DONE), 32'd0);
        pop_expect("error", K_ERR, 16'h0000, 16'h0000);
      end
      if (BUSY && !prev_busy) begin
        check("sync_halt", 32'(HALT), 32'd1);
        check("sync_err_clr", 32'(ERR), 32'd0);
        check("sync_done_clr", 32'(DONE), 32'd0);
      end
      if (!HALT && prev_halt) begin
        check("boot_rst_low_at_halt_drop", 32'(CPU_RST_N), 32'd0);
      end
      if (!HALT && !CPU_RST_N) boot_cnt++;
      if (CPU_RST_N && !prev_rstn) begin
        check("boot_len", 32'(boot_cnt), 32'(RSTC));
        check("boot_done", 32'(DONE), 32'd1);
        check("boot_busy", 32'(BUSY), 32'd0);
        check("boot_halt", 32'(HALT), 32'd0);
        pop_expect("boot", K_BOOT, 16'h0000, 16'h0000);
        boot_cnt = 0;
      end
    end
    prev_en   = EXT_RAM_EN;
    prev_err  = ERR;
    prev_busy = BUSY;
    prev_rstn = CPU_RST_N;
    prev_halt = HALT;
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    RX = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge CLK);
    end
    RX = ~bad_stop;
    repeat (CPB) @(negedge CLK);
    RX = 1'b1;
    repeat (4 + $urandom_range(0, 6)) @(negedge CLK);
  endtask

  // Reference model: build the frame from words[], queue the expected outcome,
  // then transmit it; byte index 'cut' (if >= 0) is sent with a bad stop bit.
  task automatic send_frame(input logic [15:0] base, input bit bad_chk, input int cut);
    logic [7:0]  fb[$];
    logic [7:0]  chk;
    logic [15:0] len, a;
    len = 16'(words.size());
    fb.push_back(8'hA5);
`ifdef BAT_LOADER_BASEADDR_EN
    fb.push_back(base[15:8]);
    fb.push_back(base[7:0]);
    a = base;
`else
    a = 16'h0000;
`endif
    fb.push_back(len[15:8]);
    fb.push_back(len[7:0]);
    foreach (words[i]) begin
      fb.push_back(words[i][15:8]);
      fb.push_back(words[i][7:0]);
    end
    chk = 8'h00;
    for (int i = 1; i < fb.size(); i++) chk = chk ^ fb[i];
    if (bad_chk) chk = chk ^ 8'h01;
    fb.push_back(chk);
    foreach (words[i]) begin
      if (cut < 0 || (HDR + 2 * i + 1) < cut) push_exp(K_WR, a, words[i]);
      a = a + 16'h0001;
    end
    if (cut >= 0 || bad_chk) push_exp(K_ERR, 16'h0000, 16'h0000);
    else push_exp(K_BOOT, 16'h0000, 16'h0000);
    for (int i = 0; i < fb.size(); i++) begin
      if (i == cut) begin
        send_byte(fb[i], 1'b1);
        break;
      end
      send_byte(fb[i], 1'b0);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_kind.size() != 0 && n < 3000) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_drain"}, 32'(exp_kind.size()), 32'd0);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    RST = 1'b0;
    RX  = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_halt", 32'(HALT), 32'd1);
    check("rst_cpu_rst_n", 32'(CPU_RST_N), 32'd0);
    check("rst_en", 32'(EXT_RAM_EN), 32'd0);
    check("rst_rw", 32'(EXT_RAM_RW), 32'd1);
    check("rst_addr", 32'(ADDRESS), 32'd0);
    check("rst_data", 32'(DATA), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    RST = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge CLK);

    // Basic two-word frame
    words = '{16'h1234, 16'hABCD};
    send_frame(16'h0000, 1'b0, -1);
    drain("t1");
    check("t1_done", 32'(DONE), 32'd1);
    check("t1_halt", 32'(HALT), 32'd0);
    check("t1_cpu_rst_n", 32'(CPU_RST_N), 32'd1);

    // Checksum mismatch, then recovery
    send_frame(16'h0000, 1'b1, -1);
    drain("t2_bad");
    check("t2_halt", 32'(HALT), 32'd1);
    check("t2_done", 32'(DONE), 32'd0);
    check("t2_err", 32'(ERR), 32'd1);
    check("t2_cpu_rst_n", 32'(CPU_RST_N), 32'd1);
    send_frame(16'h0000, 1'b0, -1);
    drain("t2_good");
    check("t2_err_clr", 32'(ERR), 32'd0);
    check("t2_done2", 32'(DONE), 32'd1);

    // Empty frame boots immediately
    words.delete();
    send_frame(16'h0000, 1'b0, -1);
    drain("t3");
    check("t3_done", 32'(DONE), 32'd1);

    // Framing error on the DATA_LO byte of the second word
    words = '{16'h1234, 16'hABCD};
    send_frame(16'h0000, 1'b0, HDR + 3);
    drain("t4_cut");
    check("t4_err", 32'(ERR), 32'd1);
    check("t4_busy", 32'(BUSY), 32'd0);
    check("t4_halt", 32'(HALT), 32'd1);
    rand_words(3);
    send_frame(16'h0000, 1'b0, -1);
    drain("t4_good");
    check("t4_done", 32'(DONE), 32'd1);

`ifdef BAT_LOADER_BASEADDR_EN
    // Base address wrap
    words = '{16'h5A5A, 16'hC3C3};
    send_frame(16'hFFFF, 1'b0, -1);
    drain("t5");
`endif

    // Idle glitch must not produce a byte; next frame reloads and reboots
    RX = 1'b0;
    @(negedge CLK);
    RX = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    rand_words(2);
    send_frame(16'h0000, 1'b0, -1);
    drain("t6");
    check("t6_done", 32'(DONE), 32'd1);

    // Randomized frames: length, contents, base, bad checksum, framing errors
    for (int f = 0; f < 12; f++) begin
      int n, total, cut;
      bit bad;
      n = $urandom_range(0, 4);
      rand_words(n);
      total = HDR + 2 * n + 1;
      bad = ($urandom_range(0, 3) == 0);
      cut = ($urandom_range(0, 3) == 0) ? $urandom_range(1, total - 1) : -1;
      send_frame(16'($urandom), bad, cut);
      drain("rand");
      if (cut < 0 && !bad) check("rand_done", 32'(DONE), 32'd1);
      else check("rand_err", 32'(ERR), 32'd1);
    end

    repeat (20) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end
endmodule
